// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic ops plus iterative shift-add multiply and
// restoring divide behind a valid/ready handshake, with a registered PSR {C,L,F,Z,N}.
module alu_multicycle #(
  parameter int WIDTH      = 16,
  parameter int ENABLE_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] regDst,
  input  logic [WIDTH-1:0] regSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] aluResultHi,
  output logic [4:0]       psr
);

  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  localparam int PC = 4;
  localparam int PL = 3;
  localparam int PF = 2;
  localparam int PZ = 1;
  localparam int PN = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_AND  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_ADDC = 4'b0101,
    OP_CMP  = 4'b0110,
    OP_MUL  = 4'b0111,
    OP_DIV  = 4'b1000
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // MUL high partial / DIV partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;      // MUL multiplier->low word / DIV dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;  // MUL multiplicand / DIV divisor
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [4:0]       psr_q, psr_d;

  op_e              op;
  logic             accept;
  logic             cin;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_res;
  logic [4:0]       sc_psr;
  logic             is_mul, is_div;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub, div_r_n, div_q_n;

  assign op        = op_e'(aluOp);
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign aluResult   = res_q;
  assign aluResultHi = hi_q;
  assign psr         = psr_q;

  // Single-cycle datapath and opcode decode; illegal opcodes yield 0 with PSR untouched.
  always_comb begin
    sc_res = '0;
    sc_psr = psr_q;
    is_mul = 1'b0;
    is_div = 1'b0;
    cin    = (op == OP_ADDC) && psr_q[PC];
    add_w  = {1'b0, regDst} + {1'b0, regSrc} + {{WIDTH{1'b0}}, cin};
    sub_w  = {1'b0, regDst} - {1'b0, regSrc};
    case (op)
      OP_ADD, OP_ADDC: begin
        sc_res     = add_w[M:0];
        sc_psr[PC] = add_w[WIDTH];
        sc_psr[PF] = (regDst[M] == regSrc[M]) && (add_w[M] != regDst[M]);
        sc_psr[PZ] = (add_w[M:0] == '0);
      end
      OP_AND: begin
        sc_res     = regDst & regSrc;
        sc_psr[PZ] = ((regDst & regSrc) == '0);
      end
      OP_OR: begin
        sc_res     = regDst | regSrc;
        sc_psr[PZ] = ((regDst | regSrc) == '0);
      end
      OP_XOR: begin
        sc_res     = regDst ^ regSrc;
        sc_psr[PZ] = ((regDst ^ regSrc) == '0);
      end
      OP_SUB, OP_CMP: begin
        sc_res     = sub_w[M:0];
        sc_psr[PC] = sub_w[WIDTH];
        sc_psr[PL] = sub_w[WIDTH];
        sc_psr[PF] = (regDst[M] != regSrc[M]) && (sub_w[M] != regDst[M]);
        sc_psr[PZ] = (regDst == regSrc);
        sc_psr[PN] = ($signed(regDst) < $signed(regSrc));
      end
      OP_MUL: is_mul = 1'b1;
      OP_DIV: is_div = (ENABLE_DIV != 0);
      default: ;
    endcase
  end

  // One iteration of each multi-cycle unit. A zero divisor always "fits", which
  // naturally produces an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], sh_q[M:1]};
    div_sh   = {acc_q, sh_q[M]};
    div_sub  = div_sh[M:0] - opnd_q;
    if (div_sh >= {1'b0, opnd_q}) begin
      div_r_n = div_sub;
      div_q_n = {sh_q[M-1:0], 1'b1};
    end else begin
      div_r_n = div_sh[M:0];
      div_q_n = {sh_q[M-1:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    hi_d    = hi_q;
    psr_d   = psr_q;
    case (state_q)
      ST_IDLE: ;
      ST_MUL: begin
        acc_d = mul_hi_n;
        sh_d  = mul_lo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d    = ST_DONE;
          res_d      = mul_lo_n;
          hi_d       = mul_hi_n;
          psr_d[PC]  = |mul_hi_n;
          psr_d[PF]  = 1'b0;
          psr_d[PZ]  = ~|{mul_hi_n, mul_lo_n};
        end
      end
      ST_DIV: begin
        acc_d = div_r_n;
        sh_d  = div_q_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d    = ST_DONE;
          res_d      = div_q_n;
          hi_d       = div_r_n;
          psr_d[PC]  = 1'b0;
          psr_d[PF]  = (opnd_q == '0);
          psr_d[PZ]  = (div_q_n == '0);
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An accept in DONE overrides the return to IDLE so back-to-back ops need no bubble.
    if (accept) begin
      cnt_d = CW'(WIDTH - 1);
      if (is_mul) begin
        state_d = ST_MUL;
        acc_d   = '0;
        sh_d    = regSrc;
        opnd_d  = regDst;
      end else if (is_div) begin
        state_d = ST_DIV;
        acc_d   = '0;
        sh_d    = regDst;
        opnd_d  = regSrc;
      end else begin
        state_d = ST_DONE;
        res_d   = sc_res;
        hi_d    = '0;
        psr_d   = sc_psr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      psr_q   <= psr_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: accepted ops are modelled arithmetically and
// queued; a negedge monitor compares every presented result against the queue head.
module tb_alu_multicycle;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluOp;
  logic [W-1:0] regDst;
  logic [W-1:0] regSrc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] aluResult;
  logic [W-1:0] aluResultHi;
  logic [4:0]   psr;

  alu_multicycle #(.WIDTH(W), .ENABLE_DIV(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .regDst(regDst), .regSrc(regSrc),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluResult(aluResult), .aluResultHi(aluResultHi), .psr(psr)
  );

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic [4:0]   p;
    int           lat;
    int           acc;
  } exp_t;

  exp_t     q[$];
  logic [4:0] mpsr = '0;
  int       total = 0;
  int       bad   = 0;
  int       cyc   = 0;
  int       ready_mode = 1;
  bit       in_ep = 0;
  bit       rst_seen = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; psr = {C,L,F,Z,N}.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [4:0] pin);
    exp_t e;
    int sa, sb, s, cin;
    int unsigned ua, ub, su;
    logic [31:0] prod;
    e.p = pin; e.r = '0; e.hi = '0; e.lat = 1; e.acc = 0;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    cin = (op == 4'd5 && pin[4]) ? 1 : 0;
    case (op)
      4'd0, 4'd5: begin
        su = ua + ub + cin;
        s  = sa + sb + cin;
        e.r = su[W-1:0];
        e.p[4] = (su > 32'hFFFF);
        e.p[2] = (s > 32767) || (s < -32768);
        e.p[1] = (e.r == 0);
      end
      4'd1: begin e.r = a & b; e.p[1] = (e.r == 0); end
      4'd2: begin e.r = a | b; e.p[1] = (e.r == 0); end
      4'd3: begin e.r = a ^ b; e.p[1] = (e.r == 0); end
      4'd4, 4'd6: begin
        su = ua - ub;
        s  = sa - sb;
        e.r = su[W-1:0];
        e.p[4] = (ua < ub);
        e.p[3] = (ua < ub);
        e.p[2] = (s > 32767) || (s < -32768);
        e.p[1] = (a == b);
        e.p[0] = (sa < sb);
      end
      4'd7: begin
        prod = ua * ub;
        e.r = prod[15:0]; e.hi = prod[31:16];
        e.p[4] = (e.hi != 0); e.p[2] = 1'b0; e.p[1] = (prod == 0);
        e.lat = W + 1;
      end
      4'd8: begin
        if (b == 0) begin e.r = '1; e.hi = a; e.p[2] = 1'b1; end
        else begin su = ua / ub; e.r = su[W-1:0]; su = ua % ub; e.hi = su[W-1:0]; e.p[2] = 1'b0; end
        e.p[4] = 1'b0; e.p[1] = (e.r == 0);
        e.lat = W + 1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor + scoreboard: compare/pop first, then enqueue an accept pending at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      mpsr = '0;
      in_ep = 0;
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(aluResult), 32'd0);
        chk("rst_hi", 32'(aluResultHi), 32'd0);
        chk("rst_psr", 32'(psr), 32'd0);
        rst_seen = 0;
      end
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        e = q[0];
        if (!in_ep) begin
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          in_ep = 1;
        end
        chk("result", 32'(aluResult), 32'(e.r));
        chk("result_hi", 32'(aluResultHi), 32'(e.hi));
        chk("psr", 32'(psr), 32'(e.p));
        if (out_ready) begin
          void'(q.pop_front());
          in_ep = 0;
        end else begin
          chk("in_ready_held", 32'(in_ready), 32'd0);
        end
      end else begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
      if (in_valid && in_ready) begin
        e = model(aluOp, regDst, regSrc, mpsr);
        e.acc = cyc + 1;
        mpsr = e.p;
        q.push_back(e);
      end
    end
  end

  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    aluOp = op; regDst = a; regSrc = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    aluOp  = 4'($urandom);
    regDst = W'($urandom);
    regSrc = W'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    aluOp = '0; regDst = '0; regSrc = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    issue(4'd0, 16'h7FFF, 16'h0001);
    issue(4'd4, 16'h0003, 16'h0005);
    issue(4'd6, 16'h1234, 16'h1234);
    issue(4'd0, 16'hFFFF, 16'h0001);
    issue(4'd5, 16'h0001, 16'h0001);
    issue(4'd7, 16'h1234, 16'h0010);
    issue(4'd8, 16'd100,  16'd7);
    issue(4'd8, 16'h00AB, 16'h0000);
    issue(4'hC, 16'h5555, 16'h1111);
    wait_drain();

    ready_mode = 2;
    issue(4'd3, 16'hA5A5, 16'h0FF0);
    repeat (4) @(posedge clk);
    #1 ready_mode = 1;
    wait_drain();

    issue(4'd7, 16'hBEEF, 16'h1234);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;

    ready_mode = 0;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
      issue(op, rnd_opnd(), rnd_opnd());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name:
alu_multicycle

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Adds a registered PSR (C, L, F, Z, N), carry-in add, a full-width multiply high word, and unsigned divide/remainder.
- Multiply and divide run as iterative multi-cycle units behind a valid/ready handshake.
- Sits between the register file read ports and the writeback mux; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4)
- ENABLE_DIV, 1, 0 removes the divider; DIV opcode is then treated as illegal

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an op this cycle
- aluOp  in  4  opcode (encoding below)
- regDst  in  WIDTH  destination-register operand (A)
- regSrc  in  WIDTH  source-register operand (B)
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- aluResult  out  WIDTH  primary result
- aluResultHi  out  WIDTH  MUL high word / DIV remainder, else 0
- psr  out  5  registered flags {C,L,F,Z,N} = psr[4:0]

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; out_valid=0; aluResult=0; aluResultHi=0; psr=0. Any in-flight op is discarded, including mid-MUL/DIV, with no PSR update.
- Opcodes:
  - 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB (A-B), 0101 ADDC (A+B+psr.C), 0110 CMP (A-B, result still driven), 0111 MUL (unsigned), 1000 DIV (unsigned).
  - All others are illegal: result 0, hi 0, psr unchanged, latency 1.
- States: IDLE, MUL, DIV, DONE.
- Accept: a transfer occurs when in_valid && in_ready. Operands and opcode are registered at that edge; later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back ops need no bubble.
- Single-cycle ops: accept → DONE. out_valid rises at the accept edge, i.e. result is visible the cycle after accept.
- MUL: accept → MUL for exactly WIDTH cycles (shift-add, one bit/cycle) → DONE. out_valid is seen WIDTH+1 cycles after accept.
- DIV: accept → DIV for WIDTH cycles (restoring shift-subtract) → DONE. Latency is the same as MUL.
- In MUL/DIV: in_ready=0, out_valid=0.
- DONE: out_valid=1; aluResult, aluResultHi and psr are held stable while out_ready=0.
  - out_ready=1 and no new accept → IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept → the new op proceeds as if accepted from IDLE.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - MUL: {aluResultHi, aluResult} = full 2*WIDTH product.
  - DIV: aluResult = quotient, aluResultHi = remainder.
  - Divide by zero: quotient all-ones, remainder = A, still WIDTH cycles.
- PSR update: written at the same edge out_valid rises.
  - ADDC reads psr.C as registered at its accept edge; this includes flags from an op completing in DONE, since those are already registered.
- Flag rules:
  - ADD/ADDC: C = unsigned carry-out; F = signed overflow; Z = (result==0); L, N unchanged.
  - SUB/CMP: C = borrow (A<B unsigned); F = signed overflow of A-B; Z = (A==B); L = (A<B unsigned); N = (A<B signed).
  - AND/OR/XOR: Z = (result==0); C, L, F, N unchanged.
  - MUL: C = (hi!=0); Z = (full product==0); F=0; L, N unchanged.
  - DIV: F = divide-by-zero; Z = (quotient==0); C=0; L, N unchanged.
- out_valid never asserts without a preceding accept. Exactly one out_valid episode occurs per accepted op.

Test Plan:
- ADD A=0x7FFF, B=0x0001 → aluResult 0x8000, psr C=0 F=1 Z=0, out_valid 1 cycle after accept.
- SUB A=0x0003, B=0x0005 → 0xFFFE, C=1 L=1 N=1 Z=0 F=0. Then CMP A=B=0x1234 → Z=1 L=0 N=0.
- ADD 0xFFFF+0x0001 (C=1, result 0), then ADDC 0x0001+0x0001 back-to-back with out_ready=1 → second result 0x0003, no idle bubble between out_valid pulses.
- MUL 0x1234*0x0010 → aluResult 0x2340, aluResultHi 0x0001, C=1. out_valid exactly 17 cycles after accept; in_ready=0 during MUL.
- DIV 100/7 → quotient 14, remainder 2, F=0. DIV 0x00AB/0 → 0xFFFF, hi 0x00AB, F=1.
- Hold out_ready=0 for 3 cycles after a result: outputs and psr stay stable and in_ready=0. Separately, drive reset=0 at MUL cycle 5: next cycle IDLE, out_valid=0, psr=0, no late result.
